multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Control-unit FSM for the multi-cycle CPU. It sequences every instruction through IF/ID/EXE/MEM/WB and drives the write-enable and select lines for the datapath. It sits directly upstream of the PC register: it produces PCWre, which gates PC update, and PCSrc, which selects the next-PC mux that feeds PCIn. It also drives IR, register-file, ALU and data-memory controls.

Parameters:
OPW, 6, opcode width
HALT_STICKY, 1, 1 = HALT held until reset; 0 = HALT re-enters IF on next cycle (debug only)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, synchronous, active-low
opcode  input  OPW  IR[31:26], stable from end of IF until next IF
zero  input  1  ALU zero flag, current cycle
sign  input  1  ALU result MSB, current cycle
PCWre  output  1  PC write enable; PC updates on CLK edge while high
PCSrc  output  2  00 PC+4, 01 PC+4+(imm<<2), 10 rs (jr), 11 jump target
IRWre  output  1  IR load enable
InsMemRW  output  1  instruction memory read
RegWre  output  1  register-file write enable
RegDst  output  2  00 $31, 01 rt, 10 rd
WrRegDSrc  output  1  0 PC+4, 1 DB bus
ALUSrcA  output  1  0 rs, 1 shamt
ALUSrcB  output  1  0 rt, 1 extended imm
ExtSel  output  1  0 zero-extend, 1 sign-extend
ALUOp  output  3  000 add, 001 sub, 010 sll, 011 or, 100 and, 101 slt(signed), 110 xor
mRD  output  1  data memory read
mWR  output  1  data memory write
DBDataSrc  output  1  0 ALU result, 1 memory data

Behaviour:
- Opcodes: add 000000, sub 000001, addiu 000010, and 010000, andi 010001, ori 010010, xori 010011, sll 011000, slt 100110, slti 100111, sw 110000, lw 110001, beq 110100, bne 110101, bltz 110110, j 111000, jr 111001, jal 111010, halt 111111.
- States: IF, ID, EXE_ALU, EXE_BR, EXE_LS, MEM, WB_ALU, WB_LD, HALT. State is registered. All outputs are combinational from state, opcode, zero and sign.
- Reset: when RST=0 at an edge, next state = IF. While RST=0, all outputs are forced 0 except PCWre=1, so the PC clears on the same edge. This applies mid-instruction too: e.g. during MEM, mRD/mWR drop immediately.
- IF: IRWre=1, InsMemRW=1, then go to ID.
- ID: route by class.
  - ALU ops go to EXE_ALU; lw/sw go to EXE_LS; beq/bne/bltz go to EXE_BR; halt goes to HALT.
  - j/jr/jal finish in ID and return to IF with PCWre=1 and PCSrc=11/10/11.
  - jal additionally sets RegWre=1, RegDst=00, WrRegDSrc=0.
  - Illegal opcode: NOP; PCWre=1, PCSrc=00, return to IF.
- EXE_ALU: ALUOp per opcode. ALUSrcB=1 for immediate forms. ExtSel=1 for addiu/slti, 0 for andi/ori/xori. ALUSrcA=1 for sll. Go to WB_ALU.
- WB_ALU: RegWre=1, WrRegDSrc=1, DBDataSrc=0, RegDst=10 (R-type) or 01 (I-type), PCWre=1, PCSrc=00, then IF. EXE_ALU control values are held through WB_ALU.
- EXE_LS: ALUOp=add, ALUSrcB=1, ExtSel=1, go to MEM.
- MEM: lw asserts mRD=1 and goes to WB_LD; sw asserts mWR=1, PCWre=1, PCSrc=00 and goes to IF. Address controls are held.
- WB_LD: mRD=1, DBDataSrc=1, RegWre=1, RegDst=01, WrRegDSrc=1, PCWre=1, PCSrc=00, then IF.
- EXE_BR: ALUOp=sub, ALUSrcB=0, PCWre=1, then IF.
  - beq takes when zero=1; bne when zero=0; bltz when sign=1 (rt field = $0).
  - Taken gives PCSrc=01, else 00.
- HALT: all outputs 0; with HALT_STICKY=1, stays in HALT until RST=0.
- Latency: j/jr/jal 2 cycles; branch 3; ALU 4; sw 4; lw 5.
- PCWre is high in exactly one cycle per instruction, the terminal one. It is never high in IF.

Decomposition:
- Package mc_pkg: opcode constants, state enum, ALUOp/PCSrc/RegDst encodings.
- One combinational sub-module, ctrl_decode: opcode to {class, ALUOp, ExtSel, ALUSrcA, ALUSrcB, RegDst}. The FSM gates these by state.

Test Plan:
- Reset: RST=0 for 2 cycles → PCWre=1, all other outputs 0; then RST=1 → IF with IRWre=1, InsMemRW=1, PCWre=0.
- add (000000): sequence IF,ID,EXE_ALU,WB_ALU. PCWre=1 only in WB_ALU, with PCSrc=00, RegWre=1, RegDst=10, ALUOp=000.
- lw (110001): 5 cycles; mRD=1 in MEM and WB_LD; WB_LD has DBDataSrc=1, RegDst=01. sw (110000): mWR=1 for exactly 1 cycle, 4 cycles total.
- beq with zero=1 → EXE_BR PCSrc=01, PCWre=1, 3 cycles. With zero=0 → PCSrc=00. bltz with sign=1 → PCSrc=01.
- jal (111010): 2 cycles; ID has PCWre=1, PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0. jr gives PCSrc=10.
- halt (111111): PCWre=0 for 20 cycles afterwards. Separately, RST=0 during lw MEM → mRD=0 that cycle, IF on the next cycle.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle CPU control unit: opcodes, FSM states,
// datapath select values and the decoded-instruction record.
package mc_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_AND   = 6'b010000;
    localparam logic [5:0] OP_ANDI  = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_XORI  = 6'b010011;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLT   = 6'b100110;
    localparam logic [5:0] OP_SLTI  = 6'b100111;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_BLTZ  = 6'b110110;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    // FSM state encodings
    localparam logic [3:0] S_IF      = 4'd0;
    localparam logic [3:0] S_ID      = 4'd1;
    localparam logic [3:0] S_EXE_ALU = 4'd2;
    localparam logic [3:0] S_EXE_BR  = 4'd3;
    localparam logic [3:0] S_EXE_LS  = 4'd4;
    localparam logic [3:0] S_MEM     = 4'd5;
    localparam logic [3:0] S_WB_ALU  = 4'd6;
    localparam logic [3:0] S_WB_LD   = 4'd7;
    localparam logic [3:0] S_HALT    = 4'd8;

    // ALU operation select
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b110;

    // Next-PC mux select
    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JR  = 2'b10;
    localparam logic [1:0] PC_JMP = 2'b11;

    // Register-file write address select
    localparam logic [1:0] RD_RA = 2'b00;
    localparam logic [1:0] RD_RT = 2'b01;
    localparam logic [1:0] RD_RD = 2'b10;

    typedef enum logic [3:0] {
        CL_ILL,
        CL_ALU,
        CL_LW,
        CL_SW,
        CL_BEQ,
        CL_BNE,
        CL_BLTZ,
        CL_J,
        CL_JR,
        CL_JAL,
        CL_HALT
    } iclass_t;

    typedef struct packed {
        iclass_t    cls;
        logic [2:0] alu_op;
        logic       ext_sel;
        logic       alu_src_a;
        logic       alu_src_b;
        logic [1:0] reg_dst;
    } dec_t;

endpackage

// File: rtl/ctrl_decode.sv
// Pure opcode decoder: instruction class plus the static datapath selects.
// The FSM decides in which states these values actually reach the outputs.
module ctrl_decode
    import mc_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic [OPW-1:0] opcode,
    output dec_t           dec
);

    logic [5:0] op;
    assign op = 6'(opcode);

    always_comb begin
        dec           = '0;
        dec.cls       = CL_ILL;
        dec.alu_op    = ALU_ADD;
        dec.reg_dst   = RD_RD;
        case (op)
            OP_ADD:   begin dec.cls = CL_ALU; dec.alu_op = ALU_ADD; end
            OP_SUB:   begin dec.cls = CL_ALU; dec.alu_op = ALU_SUB; end
            OP_AND:   begin dec.cls = CL_ALU; dec.alu_op = ALU_AND; end
            OP_SLT:   begin dec.cls = CL_ALU; dec.alu_op = ALU_SLT; end
            OP_SLL: begin
                dec.cls       = CL_ALU;
                dec.alu_op    = ALU_SLL;
                dec.alu_src_a = 1'b1;
            end
            OP_ADDIU: begin
                dec.cls       = CL_ALU;
                dec.alu_op    = ALU_ADD;
                dec.alu_src_b = 1'b1;
                dec.ext_sel   = 1'b1;
                dec.reg_dst   = RD_RT;
            end
            OP_ANDI: begin
                dec.cls       = CL_ALU;
                dec.alu_op    = ALU_AND;
                dec.alu_src_b = 1'b1;
                dec.reg_dst   = RD_RT;
            end
            OP_ORI: begin
                dec.cls       = CL_ALU;
                dec.alu_op    = ALU_OR;
                dec.alu_src_b = 1'b1;
                dec.reg_dst   = RD_RT;
            end
            OP_XORI: begin
                dec.cls       = CL_ALU;
                dec.alu_op    = ALU_XOR;
                dec.alu_src_b = 1'b1;
                dec.reg_dst   = RD_RT;
            end
            OP_SLTI: begin
                dec.cls       = CL_ALU;
                dec.alu_op    = ALU_SLT;
                dec.alu_src_b = 1'b1;
                dec.ext_sel   = 1'b1;
                dec.reg_dst   = RD_RT;
            end
            OP_LW: begin
                dec.cls       = CL_LW;
                dec.alu_src_b = 1'b1;
                dec.ext_sel   = 1'b1;
                dec.reg_dst   = RD_RT;
            end
            OP_SW: begin
                dec.cls       = CL_SW;
                dec.alu_src_b = 1'b1;
                dec.ext_sel   = 1'b1;
            end
            OP_BEQ:   begin dec.cls = CL_BEQ;  dec.alu_op = ALU_SUB; end
            OP_BNE:   begin dec.cls = CL_BNE;  dec.alu_op = ALU_SUB; end
            OP_BLTZ:  begin dec.cls = CL_BLTZ; dec.alu_op = ALU_SUB; end
            OP_J:     dec.cls = CL_J;
            OP_JR:    dec.cls = CL_JR;
            OP_JAL:   begin dec.cls = CL_JAL; dec.reg_dst = RD_RA; end
            OP_HALT:  dec.cls = CL_HALT;
            default:  dec.cls = CL_ILL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU control FSM: IF/ID/EXE/MEM/WB sequencing with Moore/Mealy
// control outputs for PC, IR, register file, ALU and data memory.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int OPW         = 6,
    parameter bit HALT_STICKY = 1'b1
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    input  logic           sign,
    output logic           PCWre,
    output logic [1:0]     PCSrc,
    output logic           IRWre,
    output logic           InsMemRW,
    output logic           RegWre,
    output logic [1:0]     RegDst,
    output logic           WrRegDSrc,
    output logic           ALUSrcA,
    output logic           ALUSrcB,
    output logic           ExtSel,
    output logic [2:0]     ALUOp,
    output logic           mRD,
    output logic           mWR,
    output logic           DBDataSrc
);

    logic [3:0] state;
    logic [3:0] state_nx;
    dec_t       dec;
    logic       br_taken;

    ctrl_decode #(.OPW(OPW)) u_decode (
        .opcode (opcode),
        .dec    (dec)
    );

    always_ff @(posedge CLK) begin
        if (!RST) state <= S_IF;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = S_IF;
        case (state)
            S_IF: state_nx = S_ID;
            S_ID: begin
                case (dec.cls)
                    CL_ALU:                   state_nx = S_EXE_ALU;
                    CL_LW, CL_SW:             state_nx = S_EXE_LS;
                    CL_BEQ, CL_BNE, CL_BLTZ:  state_nx = S_EXE_BR;
                    CL_HALT:                  state_nx = S_HALT;
                    default:                  state_nx = S_IF;
                endcase
            end
            S_EXE_ALU: state_nx = S_WB_ALU;
            S_EXE_LS:  state_nx = S_MEM;
            S_MEM:     state_nx = (dec.cls == CL_LW) ? S_WB_LD : S_IF;
            S_HALT:    state_nx = HALT_STICKY ? S_HALT : S_IF;
            default:   state_nx = S_IF;
        endcase
    end

    always_comb begin
        case (dec.cls)
            CL_BEQ:  br_taken = zero;
            CL_BNE:  br_taken = ~zero;
            CL_BLTZ: br_taken = sign;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        PCWre     = 1'b0;
        PCSrc     = PC_SEQ;
        IRWre     = 1'b0;
        InsMemRW  = 1'b0;
        RegWre    = 1'b0;
        RegDst    = RD_RA;
        WrRegDSrc = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ExtSel    = 1'b0;
        ALUOp     = ALU_ADD;
        mRD       = 1'b0;
        mWR       = 1'b0;
        DBDataSrc = 1'b0;
        case (state)
            S_IF: begin
                IRWre    = 1'b1;
                InsMemRW = 1'b1;
            end
            S_ID: begin
                case (dec.cls)
                    CL_J: begin
                        PCWre = 1'b1;
                        PCSrc = PC_JMP;
                    end
                    CL_JR: begin
                        PCWre = 1'b1;
                        PCSrc = PC_JR;
                    end
                    CL_JAL: begin
                        PCWre     = 1'b1;
                        PCSrc     = PC_JMP;
                        RegWre    = 1'b1;
                        RegDst    = RD_RA;
                        WrRegDSrc = 1'b0;
                    end
                    CL_ILL: PCWre = 1'b1;
                    default: ;
                endcase
            end
            // ALU selects stay up through write-back so the result is stable
            S_EXE_ALU, S_WB_ALU: begin
                ALUOp   = dec.alu_op;
                ExtSel  = dec.ext_sel;
                ALUSrcA = dec.alu_src_a;
                ALUSrcB = dec.alu_src_b;
                if (state == S_WB_ALU) begin
                    RegWre    = 1'b1;
                    WrRegDSrc = 1'b1;
                    RegDst    = dec.reg_dst;
                    PCWre     = 1'b1;
                end
            end
            // Address generation held while memory is accessed
            S_EXE_LS, S_MEM, S_WB_LD: begin
                ALUOp   = ALU_ADD;
                ALUSrcB = 1'b1;
                ExtSel  = 1'b1;
                if (state == S_MEM) begin
                    if (dec.cls == CL_LW) begin
                        mRD = 1'b1;
                    end else if (dec.cls == CL_SW) begin
                        mWR   = 1'b1;
                        PCWre = 1'b1;
                    end
                end
                if (state == S_WB_LD) begin
                    mRD       = 1'b1;
                    DBDataSrc = 1'b1;
                    RegWre    = 1'b1;
                    RegDst    = RD_RT;
                    WrRegDSrc = 1'b1;
                    PCWre     = 1'b1;
                end
            end
            S_EXE_BR: begin
                ALUOp = ALU_SUB;
                PCWre = 1'b1;
                PCSrc = br_taken ? PC_BR : PC_SEQ;
            end
            default: ;
        endcase
        if (!RST) begin
            PCSrc     = PC_SEQ;
            IRWre     = 1'b0;
            InsMemRW  = 1'b0;
            RegWre    = 1'b0;
            RegDst    = RD_RA;
            WrRegDSrc = 1'b0;
            ALUSrcA   = 1'b0;
            ALUSrcB   = 1'b0;
            ExtSel    = 1'b0;
            ALUOp     = ALU_ADD;
            mRD       = 1'b0;
            mWR       = 1'b0;
            DBDataSrc = 1'b0;
            PCWre     = 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed per-cycle expectations are
// queued by the stimulus and checked against the packed outputs by a monitor.
module tb_multicycle_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [5:0] opcode = 6'b0;
    logic       zero = 1'b0;
    logic       sign = 1'b0;

    logic       PCWre, IRWre, InsMemRW, RegWre, WrRegDSrc;
    logic       ALUSrcA, ALUSrcB, ExtSel, mRD, mWR, DBDataSrc;
    logic [1:0] PCSrc, RegDst;
    logic [2:0] ALUOp;

    always #5 CLK = ~CLK;

    multicycle_ctrl #(.OPW(6), .HALT_STICKY(1'b1)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .opcode    (opcode),
        .zero      (zero),
        .sign      (sign),
        .PCWre     (PCWre),
        .PCSrc     (PCSrc),
        .IRWre     (IRWre),
        .InsMemRW  (InsMemRW),
        .RegWre    (RegWre),
        .RegDst    (RegDst),
        .WrRegDSrc (WrRegDSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ExtSel    (ExtSel),
        .ALUOp     (ALUOp),
        .mRD       (mRD),
        .mWR       (mWR),
        .DBDataSrc (DBDataSrc)
    );

    // {PCWre,PCSrc,IRWre,InsMemRW,RegWre,RegDst,WrRegDSrc,ALUSrcA,ALUSrcB,ExtSel,ALUOp,mRD,mWR,DBDataSrc}
    logic [17:0] act;
    assign act = {PCWre, PCSrc, IRWre, InsMemRW, RegWre, RegDst, WrRegDSrc,
                  ALUSrcA, ALUSrcB, ExtSel, ALUOp, mRD, mWR, DBDataSrc};

    localparam logic [17:0] PW  = 18'h20000;
    localparam logic [17:0] IR  = 18'h04000;
    localparam logic [17:0] IM  = 18'h02000;
    localparam logic [17:0] RW  = 18'h01000;
    localparam logic [17:0] WS  = 18'h00200;
    localparam logic [17:0] SA  = 18'h00100;
    localparam logic [17:0] SB  = 18'h00080;
    localparam logic [17:0] EX  = 18'h00040;
    localparam logic [17:0] MR  = 18'h00004;
    localparam logic [17:0] MW  = 18'h00002;
    localparam logic [17:0] DB  = 18'h00001;
    localparam logic [17:0] V0  = 18'h00000;
    localparam logic [17:0] VIF = IR | IM;

    function automatic logic [17:0] psrc(input logic [1:0] p);
        return {1'b0, p, 15'b0};
    endfunction
    function automatic logic [17:0] rdst(input logic [1:0] r);
        return {6'b0, r, 10'b0};
    endfunction
    function automatic logic [17:0] aop(input logic [2:0] o);
        return {12'b0, o, 3'b0};
    endfunction

    typedef struct {
        string       name;
        logic [17:0] v;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic step(input logic rst, input logic [5:0] op, input logic z,
                        input logic s, input string nm, input logic [17:0] e);
        exp_t item;
        @(posedge CLK);
        #1;
        RST    = rst;
        opcode = op;
        zero   = z;
        sign   = s;
        item.name = nm;
        item.v    = e;
        sb_q.push_back(item);
    endtask

    // Generic IF/ID prefix for one instruction
    task automatic fetch_decode(input logic [5:0] op, input string nm, input logic [17:0] id_v);
        step(1'b1, op, 1'b0, 1'b0, {nm, "_IF"}, VIF);
        step(1'b1, op, 1'b0, 1'b0, {nm, "_ID"}, id_v);
    endtask

    task automatic alu_instr(input logic [5:0] op, input string nm,
                             input logic [17:0] exe_v, input logic [17:0] wb_v);
        fetch_decode(op, nm, V0);
        step(1'b1, op, 1'b0, 1'b0, {nm, "_EXE"}, exe_v);
        step(1'b1, op, 1'b0, 1'b0, {nm, "_WB"}, wb_v);
    endtask

    task automatic branch_instr(input logic [5:0] op, input logic z, input logic s,
                                input string nm, input logic [1:0] ps);
        fetch_decode(op, nm, V0);
        step(1'b1, op, z, s, {nm, "_EXE"}, PW | psrc(ps) | aop(3'b001));
    endtask

    always @(negedge CLK) begin
        if (sb_q.size() > 0) begin
            cur = sb_q.pop_front();
            n_checks++;
            if (act !== cur.v) begin
                n_fail++;
                $display("FAIL %s: outputs got %b expected %b", cur.name, act, cur.v);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        // Reset: only PCWre high, even before state is known
        step(1'b0, 6'b000000, 1'b0, 1'b0, "rst0", PW);
        step(1'b0, 6'b000000, 1'b0, 1'b0, "rst1", PW);

        // R-type and immediate ALU forms
        alu_instr(6'b000000, "add", V0, PW | RW | WS | rdst(2'b10));
        alu_instr(6'b010010, "ori", SB | aop(3'b011),
                  PW | RW | WS | rdst(2'b01) | SB | aop(3'b011));
        alu_instr(6'b000010, "addiu", SB | EX,
                  PW | RW | WS | rdst(2'b01) | SB | EX);
        alu_instr(6'b011000, "sll", SA | aop(3'b010),
                  PW | RW | WS | rdst(2'b10) | SA | aop(3'b010));
        alu_instr(6'b100111, "slti", SB | EX | aop(3'b101),
                  PW | RW | WS | rdst(2'b01) | SB | EX | aop(3'b101));
        alu_instr(6'b010000, "and", aop(3'b100), PW | RW | WS | rdst(2'b10) | aop(3'b100));

        // lw: 5 cycles, mRD in MEM and WB_LD
        fetch_decode(6'b110001, "lw", V0);
        step(1'b1, 6'b110001, 1'b0, 1'b0, "lw_EXE", SB | EX);
        step(1'b1, 6'b110001, 1'b0, 1'b0, "lw_MEM", SB | EX | MR);
        step(1'b1, 6'b110001, 1'b0, 1'b0, "lw_WB",
             PW | RW | rdst(2'b01) | WS | SB | EX | MR | DB);

        // sw: 4 cycles, single mWR cycle, then straight back to IF
        fetch_decode(6'b110000, "sw", V0);
        step(1'b1, 6'b110000, 1'b0, 1'b0, "sw_EXE", SB | EX);
        step(1'b1, 6'b110000, 1'b0, 1'b0, "sw_MEM", PW | SB | EX | MW);

        // Branches, taken and not taken
        branch_instr(6'b110100, 1'b1, 1'b0, "beq_t",  2'b01);
        branch_instr(6'b110100, 1'b0, 1'b0, "beq_nt", 2'b00);
        branch_instr(6'b110101, 1'b0, 1'b0, "bne_t",  2'b01);
        branch_instr(6'b110101, 1'b1, 1'b0, "bne_nt", 2'b00);
        branch_instr(6'b110110, 1'b0, 1'b1, "bltz_t", 2'b01);
        branch_instr(6'b110110, 1'b1, 1'b0, "bltz_nt", 2'b00);

        // Jumps complete in ID
        fetch_decode(6'b111010, "jal", PW | psrc(2'b11) | RW | rdst(2'b00));
        fetch_decode(6'b111001, "jr",  PW | psrc(2'b10));
        fetch_decode(6'b111000, "j",   PW | psrc(2'b11));

        // Illegal opcode behaves as NOP
        fetch_decode(6'b000011, "ill", PW);

        // Reset asserted while lw sits in MEM
        fetch_decode(6'b110001, "lwrst", V0);
        step(1'b1, 6'b110001, 1'b0, 1'b0, "lwrst_EXE", SB | EX);
        step(1'b0, 6'b110001, 1'b0, 1'b0, "lwrst_MEM", PW);
        step(1'b1, 6'b110001, 1'b0, 1'b0, "lwrst_IF", VIF);
        step(1'b1, 6'b110001, 1'b0, 1'b0, "lwrst_ID", V0);
        step(1'b0, 6'b110001, 1'b0, 1'b0, "lwrst_rst2", PW);

        // halt: sticky, all outputs low for 20 cycles
        fetch_decode(6'b111111, "halt", V0);
        for (int i = 0; i < 20; i++)
            step(1'b1, 6'b111111, 1'b1, 1'b1, "halt_hold", V0);
        step(1'b0, 6'b111111, 1'b0, 1'b0, "halt_rst", PW);
        step(1'b1, 6'b000000, 1'b0, 1'b0, "post_halt_IF", VIF);

        guard = 0;
        while (sb_q.size() > 0 && guard < 10) begin
            @(posedge CLK);
            guard++;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: scoreboard entries left %0d required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
